// File: rtl/pulse_decoder.sv
// pulse_decoder: accepts a binary line index over a valid/ready handshake and
// drives a one-hot strobe for PULSE_LEN cycles, then holds the output at zero
// for GAP_LEN cycles. An accepted index that is out of range is consumed and
// reported with a one-cycle err_o pulse instead of a strobe.
module pulse_decoder #(
  parameter  int OUTPUT_WIDTH = 8,
  parameter  int PULSE_LEN    = 1,
  parameter  int GAP_LEN      = 0,
  localparam int INDEX_WIDTH  = $clog2((OUTPUT_WIDTH > 2) ? OUTPUT_WIDTH : 2),
  localparam int CNT_WIDTH    = $clog2(((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN) + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [INDEX_WIDTH-1:0]  index_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [OUTPUT_WIDTH-1:0] out_o,
  output logic                    busy_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One extra bit so OUTPUT_WIDTH itself fits when it is a power of two.
  localparam logic [INDEX_WIDTH:0]   IDX_LIMIT  = (INDEX_WIDTH + 1)'(OUTPUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0]   PULSE_LOAD = CNT_WIDTH'(PULSE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]   GAP_LOAD   = CNT_WIDTH'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
  localparam logic                   HAS_GAP    = (GAP_LEN > 0);

  state_t                  r_state, w_state_next;
  logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_next;
  logic [OUTPUT_WIDTH-1:0] r_out, w_out_next;
  logic                    r_err, w_err_next;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_cnt_zero;
  logic [OUTPUT_WIDTH-1:0] w_onehot;

  // ready depends only on registered state so there is no valid->ready path.
  assign w_cnt_zero = (r_cnt == '0);
  assign w_ready    = (r_state == IDLE)
                    || ((r_state == DRIVE) && w_cnt_zero && !HAS_GAP)
                    || ((r_state == GAP) && w_cnt_zero);
  assign w_accept   = valid_i && w_ready;
  assign w_in_range = ({1'b0, index_i} < IDX_LIMIT);
  assign w_onehot   = OUTPUT_WIDTH'(1) << index_i;

  assign ready_o = w_ready;
  assign busy_o  = (r_state != IDLE);
  assign out_o   = r_out;
  assign err_o   = r_err;

  // State, counter and registered outputs; reset clears the strobe at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_out   <= w_out_next;
      r_err   <= w_err_next;
    end
  end

  // Next-state logic: an accept on a final cycle overrides the normal exit.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_out_next   = r_out;
    w_err_next   = 1'b0;
    if (w_accept) begin
      if (w_in_range) begin
        w_state_next = DRIVE;
        w_cnt_next   = PULSE_LOAD;
        w_out_next   = w_onehot;
      end else begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_out_next   = '0;
        w_err_next   = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_out_next = '0;
        end
        DRIVE: begin
          if (w_cnt_zero) begin
            w_out_next = '0;
            if (HAS_GAP) begin
              w_state_next = GAP;
              w_cnt_next   = GAP_LOAD;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
        GAP: begin
          w_out_next = '0;
          if (w_cnt_zero) begin
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_out_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// Directed bench for pulse_decoder: four instances cover the long pulse with
// gap, back-to-back single-cycle pulses, a non-power-of-two width and width 1.
module tb_pulse_decoder;

  logic clk_i = 1'b0;
  logic rst_n_i;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk_i = ~clk_i;

  // Instance a: OUTPUT_WIDTH=8, PULSE_LEN=3, GAP_LEN=2
  logic [2:0] a_idx;  logic a_valid, a_ready, a_busy, a_err;  logic [7:0] a_out;
  // Instance b: OUTPUT_WIDTH=8, PULSE_LEN=1, GAP_LEN=0
  logic [2:0] b_idx;  logic b_valid, b_ready, b_busy, b_err;  logic [7:0] b_out;
  // Instance c: OUTPUT_WIDTH=5, PULSE_LEN=1, GAP_LEN=0
  logic [2:0] c_idx;  logic c_valid, c_ready, c_busy, c_err;  logic [4:0] c_out;
  // Instance d: OUTPUT_WIDTH=1, PULSE_LEN=2, GAP_LEN=1
  logic [0:0] d_idx;  logic d_valid, d_ready, d_busy, d_err;  logic [0:0] d_out;

  pulse_decoder #(.OUTPUT_WIDTH(8), .PULSE_LEN(3), .GAP_LEN(2)) u_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .index_i(a_idx), .valid_i(a_valid),
    .ready_o(a_ready), .out_o(a_out), .busy_o(a_busy), .err_o(a_err));
  pulse_decoder #(.OUTPUT_WIDTH(8), .PULSE_LEN(1), .GAP_LEN(0)) u_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .index_i(b_idx), .valid_i(b_valid),
    .ready_o(b_ready), .out_o(b_out), .busy_o(b_busy), .err_o(b_err));
  pulse_decoder #(.OUTPUT_WIDTH(5), .PULSE_LEN(1), .GAP_LEN(0)) u_c (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .index_i(c_idx), .valid_i(c_valid),
    .ready_o(c_ready), .out_o(c_out), .busy_o(c_busy), .err_o(c_err));
  pulse_decoder #(.OUTPUT_WIDTH(1), .PULSE_LEN(2), .GAP_LEN(1)) u_d (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .index_i(d_idx), .valid_i(d_valid),
    .ready_o(d_ready), .out_o(d_out), .busy_o(d_busy), .err_o(d_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    a_idx = '0; a_valid = 1'b0;
    b_idx = '0; b_valid = 1'b0;
    c_idx = '0; c_valid = 1'b0;
    d_idx = '0; d_valid = 1'b0;
    step(); step();
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_out",   32'(a_out),   32'h0);
    chk("rst_err",   32'(a_err),   32'd0);
    rst_n_i = 1'b1;

    // Single transaction: index 4, pulse 3, gap 2
    $display("txn a: index 4");
    a_idx = 3'd4; a_valid = 1'b1;
    step(); a_valid = 1'b0;                      // cycle N+1
    chk("single_n1_out",   32'(a_out),   32'h10);
    chk("single_n1_ready", 32'(a_ready), 32'd0);
    chk("single_n1_busy",  32'(a_busy),  32'd1);
    step();                                      // N+2
    chk("single_n2_out",   32'(a_out),   32'h10);
    step();                                      // N+3
    chk("single_n3_out",   32'(a_out),   32'h10);
    chk("single_n3_ready", 32'(a_ready), 32'd0);
    step();                                      // N+4
    chk("single_n4_out",   32'(a_out),   32'h00);
    chk("single_n4_ready", 32'(a_ready), 32'd0);
    chk("single_n4_busy",  32'(a_busy),  32'd1);
    step();                                      // N+5
    chk("single_n5_out",   32'(a_out),   32'h00);
    chk("single_n5_ready", 32'(a_ready), 32'd1);
    chk("single_n5_busy",  32'(a_busy),  32'd1);
    step();                                      // N+6
    chk("single_n6_busy",  32'(a_busy),  32'd0);
    chk("single_n6_ready", 32'(a_ready), 32'd1);

    // Stall: index 2 offered during DRIVE, replaced by 1 before ready rises
    $display("txn a: index 5 then stalled 2->1");
    a_idx = 3'd5; a_valid = 1'b1;
    step();                                      // N+1
    a_idx = 3'd2;
    chk("stall_n1_out", 32'(a_out), 32'h20);
    step();                                      // N+2
    chk("stall_n2_out", 32'(a_out), 32'h20);
    a_idx = 3'd1;
    step();                                      // N+3
    chk("stall_n3_out", 32'(a_out), 32'h20);
    step();                                      // N+4
    chk("stall_n4_out", 32'(a_out), 32'h00);
    chk("stall_n4_ready", 32'(a_ready), 32'd0);
    step();                                      // N+5
    chk("stall_n5_ready", 32'(a_ready), 32'd1);
    step();                                      // index 1 accepted at end of N+5
    a_valid = 1'b0;
    chk("stall_new_out",  32'(a_out),  32'h02);
    chk("stall_new_busy", 32'(a_busy), 32'd1);
    step();
    chk("stall_new_out2", 32'(a_out),  32'h02);

    // Asynchronous reset mid-pulse
    $display("txn a: reset mid-pulse");
    #2 rst_n_i = 1'b0;
    #1;
    chk("amid_out",   32'(a_out),   32'h00);
    chk("amid_ready", 32'(a_ready), 32'd1);
    chk("amid_busy",  32'(a_busy),  32'd0);
    step();
    chk("amid_hold_out", 32'(a_out), 32'h00);
    rst_n_i = 1'b1;
    a_idx = 3'd0; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    chk("post_rst_out", 32'(a_out), 32'h01);

    // Back-to-back single-cycle pulses
    $display("txn b: indices 0,7,3 back-to-back");
    b_idx = 3'd0; b_valid = 1'b1;
    step(); b_idx = 3'd7;
    chk("b2b_0_out",   32'(b_out),   32'h01);
    chk("b2b_0_ready", 32'(b_ready), 32'd1);
    step(); b_idx = 3'd3;
    chk("b2b_7_out",   32'(b_out),   32'h80);
    chk("b2b_7_ready", 32'(b_ready), 32'd1);
    step(); b_valid = 1'b0;
    chk("b2b_3_out",   32'(b_out),   32'h08);
    chk("b2b_3_ready", 32'(b_ready), 32'd1);
    step();
    chk("b2b_end_out",  32'(b_out),  32'h00);
    chk("b2b_end_busy", 32'(b_busy), 32'd0);

    // Out-of-range indices on a width-5 decoder
    $display("txn c: indices 6,5,4");
    c_idx = 3'd6; c_valid = 1'b1;
    step(); c_idx = 3'd5;
    chk("oor6_err",  32'(c_err),  32'd1);
    chk("oor6_out",  32'(c_out),  32'h00);
    chk("oor6_busy", 32'(c_busy), 32'd0);
    step(); c_idx = 3'd4;
    chk("oor5_err",  32'(c_err),  32'd1);
    chk("oor5_out",  32'(c_out),  32'h00);
    step(); c_valid = 1'b0;
    chk("idx4_err",  32'(c_err),  32'd0);
    chk("idx4_out",  32'(c_out),  32'h10);
    chk("idx4_busy", 32'(c_busy), 32'd1);
    step();
    chk("c_end_out", 32'(c_out), 32'h00);
    chk("c_end_err", 32'(c_err), 32'd0);

    // Width-1 decoder
    $display("txn d: index 0 then index 1");
    d_idx = 1'b0; d_valid = 1'b1;
    step(); d_valid = 1'b0;
    chk("w1_c1_out",   32'(d_out),   32'h1);
    chk("w1_c1_ready", 32'(d_ready), 32'd0);
    step();
    chk("w1_c2_out",   32'(d_out),   32'h1);
    chk("w1_c2_ready", 32'(d_ready), 32'd0);
    step();
    chk("w1_gap_out",   32'(d_out),   32'h0);
    chk("w1_gap_ready", 32'(d_ready), 32'd1);
    step();
    chk("w1_idle_busy", 32'(d_busy), 32'd0);
    d_idx = 1'b1; d_valid = 1'b1;
    step(); d_valid = 1'b0;
    chk("w1_err",      32'(d_err),  32'd1);
    chk("w1_err_out",  32'(d_out),  32'h0);
    chk("w1_err_busy", 32'(d_busy), 32'd0);
    step();
    chk("w1_err_clr",  32'(d_err),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_decoder.md
# pulse_decoder

Sequential binary-to-one-hot decoder with a valid/ready input handshake. It turns an accepted index into a one-hot strobe on `out_o` that lasts a programmable number of cycles, optionally followed by an enforced idle gap. It sits downstream of `encoder`-style index producers and drives per-line enables (register-file write strobes, peripheral selects, interrupt acknowledges). It supports any OUTPUT_WIDTH, including non-power-of-two values, and rejects out-of-range indices.

## Interface
- OUTPUT_WIDTH, 8: number of one-hot output lines, ≥1.
- PULSE_LEN, 1: cycles `out_o` is held per transaction, ≥1.
- GAP_LEN, 0: forced all-zero cycles after each pulse, ≥0.
- Derived: INDEX_WIDTH = $clog2(`max(OUTPUT_WIDTH, 2)).
- Derived: CNT_WIDTH = $clog2(`max(PULSE_LEN, GAP_LEN) + 1).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- index_i  input  INDEX_WIDTH  binary line index to strobe.
- valid_i  input  1  index_i is valid.
- ready_o  output  1  decoder can accept; transfer occurs when valid_i && ready_o at a rising edge.
- out_o  output  OUTPUT_WIDTH  one-hot strobe, or all zero.
- busy_o  output  1  a transaction is in progress (state ≠ IDLE).
- err_o  output  1  one-cycle pulse: an accepted index was ≥ OUTPUT_WIDTH.

## Operation
- States: IDLE, DRIVE, GAP. A down-counter `cnt` of width CNT_WIDTH tracks the remaining cycles.
- Reset (asynchronous assert, takes effect immediately):
  - state = IDLE, cnt = 0, out_o = 0, err_o = 0.
  - ready_o = 1, busy_o = 0. ready_o is combinational from state/cnt, so it reads 1 while reset is held.
- ready_o = 1 in any of these cases:
  - state is IDLE;
  - last DRIVE cycle (cnt == 0) and GAP_LEN == 0;
  - last GAP cycle (cnt == 0).
- Accept with index_i < OUTPUT_WIDTH:
  - next state DRIVE, cnt = PULSE_LEN−1, out_o = 1 << index_i, err_o = 0.
- Accept with index_i ≥ OUTPUT_WIDTH:
  - next state IDLE, out_o = 0, err_o = 1 for exactly one cycle.
  - The transaction is consumed; nothing is driven.
- DRIVE behaviour:
  - out_o holds its value; cnt decrements each cycle.
  - At cnt == 0 with no accept: go to GAP with cnt = GAP_LEN−1 and out_o = 0 if GAP_LEN > 0, else go to IDLE with out_o = 0.
- GAP behaviour:
  - out_o = 0; cnt decrements each cycle.
  - At cnt == 0 with no accept: go to IDLE.
- Accept during a final cycle (the ready_o = 1 cases above): apply the accept rules directly. The new pulse follows the previous one or its gap with no IDLE cycle in between.
- valid_i while ready_o = 0 is ignored. Held valid_i/index_i are sampled only when ready_o = 1.
- OUTPUT_WIDTH == 1: INDEX_WIDTH = 1; index 0 drives out_o = 1'b1, index 1 raises err_o.
- Non-power-of-two OUTPUT_WIDTH: indices OUTPUT_WIDTH .. 2^INDEX_WIDTH−1 raise err_o.

## Timing
- Latency: accept at edge N gives out_o valid from cycle N+1 through N+PULSE_LEN.
- err_o is high during cycle N+1 only.
- Throughput: one transaction every PULSE_LEN+GAP_LEN cycles under continuous valid_i. With PULSE_LEN=1 and GAP_LEN=0 this is one per cycle, and out_o changes every cycle.
- out_o, err_o, state and cnt are registered. ready_o and busy_o are combinational from registered state only, with no path from valid_i or index_i.
- Reset mid-pulse: out_o goes to 0 asynchronously. The first accept is possible at the first rising edge after deassertion.

## Test plan
- Reset check, OUTPUT_WIDTH=8, PULSE_LEN=3, GAP_LEN=2:
  - Assert rst_n_i=0 while out_o=8'h10 mid-pulse -> out_o=0 immediately; ready_o=1, busy_o=0 during reset.
- Single transaction, same parameters:
  - Accept index 4 at edge N -> out_o=8'h10 in cycles N+1..N+3, 0 in N+4..N+5.
  - ready_o=1 only in N+5; busy_o=0 from N+6.
- Back-to-back, PULSE_LEN=1, GAP_LEN=0:
  - Indices 0,7,3 on consecutive cycles with valid_i held -> out_o = 8'h01, 8'h80, 8'h08 on consecutive cycles; ready_o stays 1.
- Out of range, OUTPUT_WIDTH=5:
  - index_i=6 accepted -> err_o=1 for one cycle, out_o=0, busy_o=0.
  - Next index 4 -> out_o=5'b10000.
- Stall:
  - Present index 2 while in DRIVE, then change to index 1 before ready_o rises -> only index 1 is strobed; index 2 is never seen on out_o.
- Width 1, OUTPUT_WIDTH=1:
  - index 0 -> out_o=1 for PULSE_LEN cycles.
  - index 1 -> err_o pulse, out_o stays 0.
